uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N requesters using round-robin scheduling.
- Sequences the transmitter's VALID/DATA_IN/PARITY_MODE inputs and tracks frame completion through the transmitter's busy flag.
- Sits between client logic (command/status generators) and the UART TX core in top.

Parameters:
- N, 4, number of requesters (1..16).
- TIMEOUT_CYCLES, 64, cycles allowed for TX_BUSY to rise after issue. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  one clock; reset is asynchronous and active-high.
- REQ  in  N  per-requester request; held until the matching GNT.
- REQ_DATA  in  8*N  byte for requester i, at bits [8i+7:8i].
- REQ_PARITY  in  2*N  parity mode for requester i: 00 none, 01 even, 10 odd, 11 none.
- GNT  out  N  one-cycle acceptance pulse, one-hot.
- TX_VALID  out  1  one-cycle start pulse to the UART TX.
- TX_DATA  out  8  byte to the UART TX.
- TX_PARITY_MODE  out  2  parity mode to the UART TX, passed through unmodified.
- TX_BUSY  in  1  UART TX frame in progress.
- ACTIVE_ID  out  max(1,$clog2(N))  index of the requester currently owning the TX.
- IDLE  out  1  high when in state S_IDLE.
- ERR  out  1  one-cycle pulse on a busy timeout.

Behaviour:
- All outputs are registered.
- Reset values: GNT=0, TX_VALID=0, TX_DATA=8'h00, TX_PARITY_MODE=2'b00, ACTIVE_ID=0, IDLE=1, ERR=0. Internal PTR=0, state S_IDLE.
- States: S_IDLE, S_WAIT_BUSY, S_WAIT_DONE.
- S_IDLE:
  - Arbitrates only when |REQ and TX_BUSY==0. If TX_BUSY is high, it stalls with no grant.
  - Winner w is the first i with REQ[i]=1, searching PTR, PTR+1, … mod N.
  - On the next edge: GNT[w]=1 and TX_VALID=1, each for exactly one cycle. TX_DATA and TX_PARITY_MODE latch requester w's fields. ACTIVE_ID=w. PTR=(w+1) mod N. Go to S_WAIT_BUSY.
  - Latency: REQ sampled at edge k gives GNT/TX_VALID high during cycle k+1.
- S_WAIT_BUSY: stays until TX_BUSY=1, then goes to S_WAIT_DONE.
- S_WAIT_DONE: stays until TX_BUSY=0, then goes to S_IDLE.
  - At least one S_IDLE cycle separates consecutive TX_VALID pulses.
- TX_DATA, TX_PARITY_MODE and ACTIVE_ID hold stable from issue until the next grant. They are never cleared between frames.
- REQ changes outside S_IDLE are ignored. A REQ withdrawn before its grant is simply not served.
- Requester handshake: the requester drops REQ, or presents its next byte, in the cycle after GNT. A REQ still high on return to S_IDLE is a new request.
- Simultaneous requests are served in strict rotation, with no starvation. Worst-case wait is N-1 frames.
- N=1: PTR is constant 0 and behaviour is otherwise identical.
- RST asserted mid-frame aborts immediately to reset values. The UART TX shares RST and is reset too.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in S_WAIT_BUSY.
  - If TX_BUSY has not risen after TIMEOUT_CYCLES cycles, ERR pulses for one cycle and the FSM returns to S_IDLE.
  - PTR keeps its advanced value and the frame is dropped, not retried.
- Undefined: no counter is built, S_WAIT_BUSY waits indefinitely, and ERR is tied to 0.

Decomposition:
- Package uart_arb_pkg holds:
  - parity_mode_e enum: PAR_NONE=00, PAR_EVEN=01, PAR_ODD=10, PAR_NONE2=11.
  - arb_state_e enum.
  - Default constants for N and TIMEOUT_CYCLES.
- Sub-module rr_arbiter_core contains the PTR register, rotate-and-priority-pick logic and the pointer update on grant.
  - Inputs: REQ, advance strobe.
  - Outputs: one-hot winner, winner index.

Test Plan:
- Reset: RST=1 with REQ=4'hF and TX_BUSY=0 gives all outputs at reset values. Release RST; on the next edge GNT=4'b0001 and TX_VALID=1.
- Single request: REQ[2]=1, REQ_DATA byte2=8'hA3, REQ_PARITY=01, TX_BUSY modelled rising 2 cycles after TX_VALID and high for 200 ns.
  - Expect: one GNT[2] pulse, TX_DATA=8'hA3, TX_PARITY_MODE=01, ACTIVE_ID=2.
  - Expect: IDLE returns one cycle after TX_BUSY falls.
- Round robin: REQ=4'hF held constantly with bytes 8'h10/11/12/13. Grant order is 0,1,2,3,0 and TX_DATA follows 10,11,12,13,10.
- Busy stall: TX_BUSY=1 while in S_IDLE and REQ[1]=1. No GNT and no TX_VALID until TX_BUSY=0, then the grant follows on the next edge.
- Reset mid-frame: assert RST during S_WAIT_DONE with ACTIVE_ID=3. Outputs go to reset values immediately (asynchronously), and the next grant starts from requester 0.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): TX_BUSY stuck at 0 after issue gives an ERR pulse 8 cycles after TX_VALID, IDLE=1, and the next pending requester granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART TX arbiter.
package uart_arb_pkg;

   localparam int unsigned N_DEFAULT       = 4;
   localparam int unsigned TIMEOUT_DEFAULT = 64;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_EVEN  = 2'b01,
      PAR_ODD   = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_mode_e;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter_core.sv
// Round-robin pick: rotating priority pointer, winner selection and pointer advance.
module rr_arbiter_core #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N-1:0]   req,
   input  logic           advance,
   output logic [N-1:0]   win_oh,
   output logic [IDW-1:0] win_id,
   output logic           win_any
);

   logic [IDW-1:0] ptr_q;
   int unsigned    best_d;
   int unsigned    d;

   // Winner is the requester with the smallest rotated distance from the pointer.
   always_comb begin
      win_id  = '0;
      win_any = 1'b0;
      best_d  = N;
      d       = 0;
      for (int unsigned j = 0; j < N; j++) begin
         if (req[j]) begin
            d = (j >= 32'(ptr_q)) ? (j - 32'(ptr_q)) : (j + N - 32'(ptr_q));
            if (d < best_d) begin
               best_d  = d;
               win_id  = IDW'(j);
               win_any = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_oh = '0;
      for (int unsigned j = 0; j < N; j++) begin
         win_oh[j] = win_any && (win_id == IDW'(j));
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= (32'(win_id) == N - 1) ? '0 : IDW'(win_id + IDW'(1));
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N requesters.
// Optional busy-rise timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned N              = N_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   localparam int unsigned IDW           = (N > 1) ? $clog2(N) : 1
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N-1:0]   REQ,
   input  logic [8*N-1:0] REQ_DATA,
   input  logic [2*N-1:0] REQ_PARITY,
   output logic [N-1:0]   GNT,
   output logic           TX_VALID,
   output logic [7:0]     TX_DATA,
   output logic [1:0]     TX_PARITY_MODE,
   input  logic           TX_BUSY,
   output logic [IDW-1:0] ACTIVE_ID,
   output logic           IDLE,
   output logic           ERR
);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           valid_q, valid_d;
   logic [7:0]     data_q, data_d;
   parity_mode_e   par_q, par_d;
   logic [IDW-1:0] id_q, id_d;
   logic           idle_q;
   logic           advance;
   logic [N-1:0]   win_oh;
   logic [IDW-1:0] win_id;
   logic           win_any;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   rr_arbiter_core #(.N(N), .IDW(IDW)) u_core (
      .CLK     (CLK),
      .RST     (RST),
      .req     (REQ),
      .advance (advance),
      .win_oh  (win_oh),
      .win_id  (win_id),
      .win_any (win_any)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      valid_d = 1'b0;
      data_d  = data_q;
      par_d   = par_q;
      id_d    = id_q;
      advance = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_any && !TX_BUSY) begin
               gnt_d   = win_oh;
               valid_d = 1'b1;
               id_d    = win_id;
               advance = 1'b1;
               state_d = S_WAIT_BUSY;
               for (int unsigned j = 0; j < N; j++) begin
                  if (win_oh[j]) begin
                     data_d = REQ_DATA[8*j +: 8];
                     par_d  = parity_mode_e'(REQ_PARITY[2*j +: 2]);
                  end
               end
            end
         end
         S_WAIT_BUSY: begin
            if (TX_BUSY) begin
               state_d = S_WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // Frame is dropped on timeout; the pointer has already moved on.
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         S_WAIT_DONE: begin
            if (!TX_BUSY) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         par_q   <= PAR_NONE;
         id_q    <= '0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         par_q   <= par_d;
         id_q    <= id_d;
         idle_q  <= (state_d == S_IDLE);
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign GNT            = gnt_q;
   assign TX_VALID       = valid_q;
   assign TX_DATA        = data_q;
   assign TX_PARITY_MODE = par_q;
   assign ACTIVE_ID      = id_q;
   assign IDLE           = idle_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for round robin plus hand sequences.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  REQ;
   logic [31:0] REQ_DATA;
   logic [7:0]  REQ_PARITY;
   logic [3:0]  GNT;
   logic        TX_VALID;
   logic [7:0]  TX_DATA;
   logic [1:0]  TX_PARITY_MODE;
   logic        TX_BUSY;
   logic [1:0]  ACTIVE_ID;
   logic        IDLE;
   logic        ERR;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [3:0] req;
      logic       busy;
      logic [3:0] gnt;
      logic       valid;
      logic [7:0] data;
      logic [1:0] id;
      logic       idle;
   } vec_t;

   vec_t tbl [15];

   always #10 CLK = ~CLK;

   uart_tx_arbiter #(.N(4), .TIMEOUT_CYCLES(8)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .REQ            (REQ),
      .REQ_DATA       (REQ_DATA),
      .REQ_PARITY     (REQ_PARITY),
      .GNT            (GNT),
      .TX_VALID       (TX_VALID),
      .TX_DATA        (TX_DATA),
      .TX_PARITY_MODE (TX_PARITY_MODE),
      .TX_BUSY        (TX_BUSY),
      .ACTIVE_ID      (ACTIVE_ID),
      .IDLE           (IDLE),
      .ERR            (ERR)
   );

   // Compare the full output bundle {GNT,TX_VALID,TX_DATA,PAR,ID,IDLE,ERR}.
   task automatic expect_all(input string name, input logic [3:0] g, input logic v,
                             input logic [7:0] d, input logic [1:0] p, input logic [1:0] id,
                             input logic idl, input logic e);
      logic [18:0] act, exp;
      act = {GNT, TX_VALID, TX_DATA, TX_PARITY_MODE, ACTIVE_ID, IDLE, ERR};
      exp = {g, v, d, p, id, idl, e};
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got gnt=%b v=%b d=%h p=%b id=%0d idle=%b err=%b, expected gnt=%b v=%b d=%h p=%b id=%0d idle=%b err=%b",
                  name, GNT, TX_VALID, TX_DATA, TX_PARITY_MODE, ACTIVE_ID, IDLE, ERR,
                  g, v, d, p, id, idl, e);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic b);
      REQ     = r;
      TX_BUSY = b;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [7:0] rr_bytes [4];
      rr_bytes[0] = 8'h10; rr_bytes[1] = 8'h11; rr_bytes[2] = 8'h12; rr_bytes[3] = 8'h13;

      // Round robin with REQ=F: five frames of grant / busy high / busy low.
      for (int f = 0; f < 5; f++) begin
         tbl[3*f]     = '{4'hF, 1'b0, 4'(1 << (f % 4)), 1'b1, rr_bytes[f % 4], 2'(f % 4), 1'b0};
         tbl[3*f + 1] = '{4'hF, 1'b1, 4'h0, 1'b0, rr_bytes[f % 4], 2'(f % 4), 1'b0};
         tbl[3*f + 2] = '{4'hF, 1'b0, 4'h0, 1'b0, rr_bytes[f % 4], 2'(f % 4), 1'b1};
      end

      RST        = 1'b1;
      REQ        = 4'hF;
      TX_BUSY    = 1'b0;
      REQ_DATA   = 32'h13121110;
      REQ_PARITY = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      expect_all("reset", 4'h0, 1'b0, 8'h00, 2'b00, 2'd0, 1'b1, 1'b0);
      RST = 1'b0;

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].req, tbl[i].busy);
         expect_all($sformatf("rr[%0d]", i), tbl[i].gnt, tbl[i].valid, tbl[i].data,
                    2'b00, tbl[i].id, tbl[i].idle, 1'b0);
      end

      // Single request from 2; pointer sits at 1.
      REQ_DATA   = 32'h13A31110;
      REQ_PARITY = 8'b00_01_00_00;
      step(4'b0100, 1'b0);
      expect_all("single_grant", 4'b0100, 1'b1, 8'hA3, 2'b01, 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b0);
         expect_all("single_wait_busy", 4'h0, 1'b0, 8'hA3, 2'b01, 2'd2, 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step(4'b0000, 1'b1);
         expect_all("single_busy", 4'h0, 1'b0, 8'hA3, 2'b01, 2'd2, 1'b0, 1'b0);
      end
      step(4'b0000, 1'b0);
      expect_all("single_idle_return", 4'h0, 1'b0, 8'hA3, 2'b01, 2'd2, 1'b1, 1'b0);

      // Busy stall in idle: no grant until the transmitter is free.
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 1'b1);
         expect_all("stall", 4'h0, 1'b0, 8'hA3, 2'b01, 2'd2, 1'b1, 1'b0);
      end
      step(4'b0010, 1'b0);
      expect_all("stall_release", 4'b0010, 1'b1, 8'h11, 2'b00, 2'd1, 1'b0, 1'b0);
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b0);
      expect_all("stall_done", 4'h0, 1'b0, 8'h11, 2'b00, 2'd1, 1'b1, 1'b0);

      // Reset in the middle of a frame owned by requester 3.
      step(4'b1000, 1'b0);
      expect_all("mid_grant3", 4'b1000, 1'b1, 8'h13, 2'b00, 2'd3, 1'b0, 1'b0);
      step(4'b0000, 1'b1);
      expect_all("mid_wait_done", 4'h0, 1'b0, 8'h13, 2'b00, 2'd3, 1'b0, 1'b0);
      RST = 1'b1;
      #2;
      expect_all("mid_async_reset", 4'h0, 1'b0, 8'h00, 2'b00, 2'd0, 1'b1, 1'b0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      step(4'hF, 1'b0);
      expect_all("post_reset_grant0", 4'b0001, 1'b1, 8'h10, 2'b00, 2'd0, 1'b0, 1'b0);
      step(4'h0, 1'b1);
      step(4'h0, 1'b0);
      expect_all("post_reset_idle", 4'h0, 1'b0, 8'h10, 2'b00, 2'd0, 1'b1, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
      // Busy never rises: ERR after 8 cycles, then the next pending requester.
      step(4'b0110, 1'b0);
      expect_all("to_grant1", 4'b0010, 1'b1, 8'h11, 2'b00, 2'd1, 1'b0, 1'b0);
      for (int i = 1; i < 8; i++) begin
         step(4'b0100, 1'b0);
         expect_all("to_wait", 4'h0, 1'b0, 8'h11, 2'b00, 2'd1, 1'b0, 1'b0);
      end
      step(4'b0100, 1'b0);
      expect_all("to_err", 4'h0, 1'b0, 8'h11, 2'b00, 2'd1, 1'b1, 1'b1);
      step(4'b0100, 1'b0);
      expect_all("to_next_grant2", 4'b0100, 1'b1, 8'hA3, 2'b01, 2'd2, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
